wm_extraction: RTL
==================

Name: wm_extraction

Overview:
- Non-blind watermark extractor; the decode side of the pixel-insertion path.
- Takes each watermarked pixel plus its original cover pixels (Data1..Data3) and regenerates all four insertion candidates.
- Recovers the embedded 2-bit WM_data symbol by exact comparison against those candidates.
- Streams one pixel per cycle through a 3-stage pipeline, frames PIXELS pixels per start, and accumulates per-frame mismatch statistics for the verification/readout logic.

Parameters:
- PIXELS, 1024: pixels per frame (1..65535).
- COEF_A, 8'd128: unsigned Q0.8 coefficient applied to the neighbourhood average.
- COEF_B, 8'd64: unsigned Q0.8 coefficient applied to Data2 (code 10).
- COEF_C, 8'd192: unsigned Q0.8 coefficient applied to Data1 (code 01).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; opens a frame when IDLE.
- in_valid  in  1  input pixel valid.
- in_ready  out  1  block accepts a pixel this cycle.
- Data1  in  8  original cover pixel.
- Data2  in  8  cover neighbour 1.
- Data3  in  8  cover neighbour 2.
- WM_IM_Data  in  8  received watermarked pixel.
- out_valid  out  1  decoded symbol valid (one-cycle pulse per pixel).
- WM_data  out  2  decoded watermark symbol.
- match  out  1  1 = received pixel equals a candidate.
- err_count  out  16  no-match pixels in the current/last frame.
- busy  out  1  frame in progress.
- frame_done  out  1  one-cycle pulse after the last output of a frame.

Behaviour:
- Reset (async, rst_n=0): state IDLE; all pipeline valids cleared; in_ready, out_valid, match, busy, frame_done = 0; WM_data = 2'b00; err_count = 0; pixel counter = 0.
- Reset mid-frame aborts the frame; no frame_done is issued.
- Arithmetic, all unsigned:
  - s1 = (Data1+Data2)>>1, using a 9-bit sum.
  - s2 = (Data3+s1)>>1, using a 9-bit sum.
  - Coefficient multiply: mul(x,K) = (x*K)>>8, 16-bit product, result 8 bits.
  - m2 = mul(s2,COEF_A).
- Candidates:
  - c00 = Data1.
  - c01 = (mul(Data1,COEF_C)+m2) mod 256.
  - c10 = (mul(Data2,COEF_B)+m2) mod 256.
  - c11 = m2.
  - The 9-bit sum is truncated to its low 8 bits; wrap-around is required.
- Pipeline:
  - S1 registers inputs and s1.
  - S2 registers s2 and the products.
  - S3 registers the compare result.
  - Latency is exactly 3 cycles from the accept edge (in_valid & in_ready) to out_valid.
- Decode:
  - Priority on multiple equal candidates: 00 > 01 > 10 > 11.
  - No candidate equal: WM_data = 00, match = 0, err_count += 1, saturating at 16'hFFFF.
- FSM IDLE -> RUN -> DRAIN -> IDLE:
  - IDLE: start=1 -> RUN; clear err_count and the pixel counter. start has no effect in RUN or DRAIN.
  - RUN: in_ready = 1; each accept increments the counter. The accept where counter = PIXELS-1 -> DRAIN. in_valid=0 stalls with no bubble penalty.
  - DRAIN: in_ready = 0; wait until the pipeline is empty; frame_done = 1 for one cycle (the cycle after the last out_valid) -> IDLE.
  - busy = 1 in RUN and DRAIN.
- start arriving in the same cycle frame_done is high is ignored; start is honoured in IDLE only.
- WM_data, match and err_count hold their values between out_valid pulses and after the frame ends.

Decomposition:
- Package wm_pkg:
  - WM symbol constants WM_NONE=2'b00, WM_C=2'b01, WM_B=2'b10, WM_A=2'b11.
  - Default COEF_A/B/C values.
  - State encoding for IDLE/RUN/DRAIN.
- One sub-module, wm_predict: 2-stage registered candidate generator (s1/s2/products -> c00..c11), parameterised by the coefficients. Shared with future insertion rework so both ends compute identical candidates.
- Top level holds the FSM, counter, compare and statistics.

Test Plan:
- Data1=100, Data2=60, Data3=40 (candidates 100/105/45/30); feed WM_IM_Data = 100, 105, 45, 30 on consecutive cycles -> WM_data 00, 01, 10, 11, all match=1, out_valid exactly 3 cycles after each accept, err_count=0.
- Same cover pixels with WM_IM_Data=77 -> WM_data=00, match=0, err_count=1.
- Wrap: Data1=Data2=Data3=255, WM_IM_Data=62 -> WM_data=01 (191+127=318 mod 256); WM_IM_Data=190 -> 10.
- Tie: Data1=Data2=Data3=0, WM_IM_Data=0 -> all candidates 0, WM_data=00 (priority), match=1.
- Framing with PIXELS=4: start, then in_valid toggling 1,0,1,1,0,1; extra in_valid and a second start mid-frame -> exactly 4 accepts, in_ready=0 after the 4th, frame_done pulses once the cycle after the 4th out_valid, the extra start is ignored.
- Assert rst_n=0 during DRAIN -> all outputs return to reset values immediately, no frame_done; a new start then runs a clean frame with err_count restarting at 0.

Source files
------------

// File: rtl/wm_pkg.sv
// Shared constants, types and fixed-point helper for the watermark pixel path.
// Both insertion and extraction import this so they agree on symbol codes and math.
package wm_pkg;

    localparam logic [1:0] WM_NONE = 2'b00;
    localparam logic [1:0] WM_C    = 2'b01;
    localparam logic [1:0] WM_B    = 2'b10;
    localparam logic [1:0] WM_A    = 2'b11;

    localparam logic [7:0] DEF_COEF_A = 8'd128;
    localparam logic [7:0] DEF_COEF_B = 8'd64;
    localparam logic [7:0] DEF_COEF_C = 8'd192;

    // Number of registered stages from accept to out_valid.
    localparam int STAGES = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic [7:0] c00;
        logic [7:0] c01;
        logic [7:0] c10;
        logic [7:0] c11;
    } cand_t;

    // Unsigned Q0.8 multiply: keep the integer byte of the 16-bit product.
    function automatic logic [7:0] qmul(input logic [7:0] x, input logic [7:0] k);
        return 8'(({8'd0, x} * {8'd0, k}) >> 8);
    endfunction

endpackage

// File: rtl/wm_predict.sv
// Two-stage registered generator of the four insertion candidates.
// Candidates are valid two cycles after the cover pixels are presented.
module wm_predict
    import wm_pkg::*;
#(
    parameter logic [7:0] COEF_A = DEF_COEF_A,
    parameter logic [7:0] COEF_B = DEF_COEF_B,
    parameter logic [7:0] COEF_C = DEF_COEF_C
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data1,
    input  logic [7:0] data2,
    input  logic [7:0] data3,
    output cand_t      cand
);

    logic [7:0] s1;
    logic [7:0] s2;
    logic [7:0] d1_q, d2_q, d3_q, s1_q;
    logic [7:0] d1_qq, m2_q, pb_q, pc_q;

    assign s1 = 8'(({1'b0, data1} + {1'b0, data2}) >> 1);
    assign s2 = 8'(({1'b0, d3_q} + {1'b0, s1_q}) >> 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d1_q  <= '0;
            d2_q  <= '0;
            d3_q  <= '0;
            s1_q  <= '0;
            d1_qq <= '0;
            m2_q  <= '0;
            pb_q  <= '0;
            pc_q  <= '0;
        end else begin
            d1_q  <= data1;
            d2_q  <= data2;
            d3_q  <= data3;
            s1_q  <= s1;
            d1_qq <= d1_q;
            m2_q  <= qmul(s2, COEF_A);
            pb_q  <= qmul(d2_q, COEF_B);
            pc_q  <= qmul(d1_q, COEF_C);
        end
    end

    // 8-bit adds wrap modulo 256 on purpose.
    always_comb begin
        cand.c00 = d1_qq;
        cand.c01 = pc_q + m2_q;
        cand.c10 = pb_q + m2_q;
        cand.c11 = m2_q;
    end

endmodule

// File: rtl/wm_extraction.sv
// Non-blind watermark extractor: frames pixels, recovers the 2-bit symbol per pixel
// by exact match against regenerated candidates, and counts unmatched pixels.
module wm_extraction
    import wm_pkg::*;
#(
    parameter int         PIXELS = 1024,
    parameter logic [7:0] COEF_A = DEF_COEF_A,
    parameter logic [7:0] COEF_B = DEF_COEF_B,
    parameter logic [7:0] COEF_C = DEF_COEF_C
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  Data1,
    input  logic [7:0]  Data2,
    input  logic [7:0]  Data3,
    input  logic [7:0]  WM_IM_Data,
    output logic        out_valid,
    output logic [1:0]  WM_data,
    output logic        match,
    output logic [15:0] err_count,
    output logic        busy,
    output logic        frame_done
);

    localparam logic [15:0] LAST = 16'(PIXELS - 1);

    state_t            state, state_nxt;
    logic              accept;
    logic [STAGES:1]   vld_pipe;
    logic [15:0]       pix_cnt;
    logic [7:0]        wm_s1, wm_s2;
    cand_t             cand;
    logic [1:0]        sym_nxt;
    logic              hit;

    wm_predict #(
        .COEF_A(COEF_A),
        .COEF_B(COEF_B),
        .COEF_C(COEF_C)
    ) u_predict (
        .clk  (clk),
        .rst_n(rst_n),
        .data1(Data1),
        .data2(Data2),
        .data3(Data3),
        .cand (cand)
    );

    assign in_ready  = (state == ST_RUN);
    assign busy      = (state != ST_IDLE);
    assign accept    = in_valid & in_ready;
    assign out_valid = vld_pipe[STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        frame_done = 1'b0;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_RUN;
            ST_RUN:   if (accept && pix_cnt == LAST) state_nxt = ST_DRAIN;
            ST_DRAIN: begin
                // No accepts in DRAIN, so an empty pipe means the last output just left.
                if (vld_pipe == '0) begin
                    frame_done = 1'b1;
                    state_nxt  = ST_IDLE;
                end
            end
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Priority 00 > 01 > 10 > 11 when several candidates coincide.
    always_comb begin
        hit     = 1'b1;
        sym_nxt = WM_NONE;
        if (wm_s2 == cand.c00)      sym_nxt = WM_NONE;
        else if (wm_s2 == cand.c01) sym_nxt = WM_C;
        else if (wm_s2 == cand.c10) sym_nxt = WM_B;
        else if (wm_s2 == cand.c11) sym_nxt = WM_A;
        else                        hit     = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe  <= '0;
            wm_s1     <= '0;
            wm_s2     <= '0;
            pix_cnt   <= '0;
            err_count <= '0;
            WM_data   <= WM_NONE;
            match     <= 1'b0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:1], accept};
            wm_s1    <= WM_IM_Data;
            wm_s2    <= wm_s1;
            if (state == ST_IDLE && start) begin
                pix_cnt   <= '0;
                err_count <= '0;
            end else if (accept) begin
                pix_cnt <= pix_cnt + 16'd1;
            end
            if (vld_pipe[STAGES-1]) begin
                WM_data <= sym_nxt;
                match   <= hit;
                if (!hit && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
            end
        end
    end

endmodule
